mem_readback_streamer: RTL and testbench

- Reader-side engine for the inferred block-RAM `memory` module.
- On a start command it sweeps a contiguous address range through the RAM read port (`raddr`/`dout`, 1-cycle registered read).
- It returns the words as a valid/ready stream with backpressure.
- Used to dump RAM contents after bitstream reinitialisation so they can be compared against the init file.

---
 rtl/mem_readback_streamer_if.sv | 28 ++
 rtl/mem_readback_streamer.sv | 173 +++++++++++++++++
 tb/tb_mem_readback_streamer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_readback_streamer_if.sv
// Output stream bundle for mem_readback_streamer.
//   out_data  : stream word (WID bits)
//   out_valid : word on out_data is valid
//   out_ready : sink can accept a word this cycle
//   out_last  : word on out_data is the final word of the transfer
// The master modport is the streamer side; the slave modport is the sink side.
interface mem_readback_streamer_if #(
    parameter int WID = 1
);
    logic [WID-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_readback_streamer.sv
// Reader-side engine for the inferred block RAM: on a start pulse it sweeps
// [start_addr, start_addr+num_words) through the RAM read port (1-cycle
// registered read) and returns the words as a valid/ready stream.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : command pulse, sampled only while idle
//   start_addr, num_words: first word address and word count
//   raddr / mem_dout     : RAM read address / read data (data 1 cycle later)
//   strm                 : output stream (out_data/out_valid/out_ready/out_last)
//   busy                 : transfer in progress (through the done cycle)
//   done / err           : one-cycle completion pulse / range error flag
module mem_readback_streamer #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 16384,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [31:0]         num_words,
    output logic [31:0]         raddr,
    input  logic [WID_MEM-1:0]  mem_dout,
    mem_readback_streamer_if.master strm,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [31:0]        addr_cnt;
    logic [31:0]        issue_rem;
    logic [31:0]        beat_rem;
    logic               err_flag;
    logic [1:0]         rd_vld;      // [0]: raddr stage, [1]: memory stage
    logic [WID_MEM-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;

    logic               pop;
    logic               push;
    logic               issue;
    logic [31:0]        issue_addr;
    logic [31:0]        issue_cnt;
    logic               range_bad;
    logic [32:0]        end_addr;
    logic [CW:0]        credit_use;
    logic               credit_ok;

    assign pop  = strm.out_valid && strm.out_ready;
    assign push = rd_vld[1];

    assign end_addr  = {1'b0, start_addr} + {1'b0, num_words};
    assign range_bad = end_addr > 33'(DEPTH_MEM);

    // Buffer slots already promised: stored words plus reads still in the pipe,
    // minus the word leaving this cycle.
    assign credit_use = (CW+1)'(occ) + (CW+1)'(rd_vld[0]) + (CW+1)'(rd_vld[1])
                      - (CW+1)'(pop);
    assign credit_ok  = credit_use < (CW+1)'(BUF_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The first read is issued straight from IDLE on the accepted start so
    // that the first word reaches the buffer two edges after the command;
    // ISSUE then continues from start_addr+1 with num_words-1 remaining.
    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        issue_addr = addr_cnt;
        issue_cnt  = issue_rem;
        case (state)
            S_IDLE: begin
                issue_addr = start_addr;
                issue_cnt  = num_words;
                if (start) begin
                    if (num_words == '0 || range_bad) begin
                        state_nx = S_DONE;
                    end else begin
                        issue    = 1'b1;
                        state_nx = (num_words == 32'd1) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_rem == 32'd1) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave on the edge that accepts the final beat.
                if (rd_vld == '0 && (occ == '0 || (occ == CW'(1) && pop))) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign err  = done && err_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr     <= '0;
            addr_cnt  <= '0;
            issue_rem <= '0;
            beat_rem  <= '0;
            err_flag  <= 1'b0;
            rd_vld    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
        end else begin
            rd_vld <= {rd_vld[0], issue};
            if (issue) begin
                raddr     <= issue_addr;
                addr_cnt  <= issue_addr + 32'd1;
                issue_rem <= issue_cnt - 32'd1;
            end
            if (state == S_IDLE && start) begin
                err_flag <= (num_words != '0) && range_bad;
                beat_rem <= num_words;
            end else if (pop) begin
                beat_rem <= beat_rem - 32'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= mem_dout;
        end
    end

    assign strm.out_data  = buf_mem[rd_ptr];
    assign strm.out_valid = (occ != '0);
    assign strm.out_last  = strm.out_valid && (beat_rem == 32'd1);

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Self-checking bench for mem_readback_streamer with a small behavioural RAM.
// Expected words come straight from the RAM array contents and the command's
// address range; timing expectations come from the documented latencies.
module tb_mem_readback_streamer;
    localparam int W = 8;
    localparam int D = 16;
    localparam int B = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   start_addr;
    logic [31:0]   num_words;
    logic [31:0]   raddr;
    logic [W-1:0]  mem_dout;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  ram [D];

    int n_tests = 0;
    int n_fail  = 0;

    mem_readback_streamer_if #(.WID(W)) strm_if ();

    mem_readback_streamer #(
        .WID_MEM   (W),
        .DEPTH_MEM (D),
        .BUF_DEPTH (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .num_words  (num_words),
        .raddr      (raddr),
        .mem_dout   (mem_dout),
        .strm       (strm_if),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Attached memory: 1-cycle registered read.
    always @(posedge clk) mem_dout <= ram[raddr[3:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready; 1: pattern 1,0,0,1; 2: stalled for 10 cycles; 3: random
    task automatic set_ready(input int mode, input int cyc);
        case (mode)
            0: strm_if.out_ready = 1'b1;
            1: strm_if.out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
            2: strm_if.out_ready = (cyc > 10);
            default: strm_if.out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run_cmd(input logic [31:0] sa, input logic [31:0] nw, input int mode,
                           input bit restart, input int abort_after);
        logic [31:0]  raddr0;
        longint       sum;
        bit           exp_err;
        int           k;
        int           cyc;
        int           last_cyc;
        int           first_cyc;
        bit           finished;
        bit           prev_stall;
        logic [W-1:0] prev_data;
        logic         prev_last;
        logic [3:0]   idx;

        raddr0   = raddr;
        sum      = longint'(sa) + longint'(nw);
        exp_err  = (nw != 0) && (sum > D);

        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        num_words  = nw;
        set_ready(mode, 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;

        if (nw == 0 || sum > D) begin
            check("immediate_done", done, 1);
            check("immediate_err", err, exp_err);
            check("immediate_no_valid", strm_if.out_valid, 0);
            @(negedge clk);
            check("immediate_done_clear", done, 0);
            check("immediate_raddr_held", raddr, raddr0);
            check("immediate_no_beat", strm_if.out_valid, 0);
            return;
        end

        k          = 0;
        last_cyc   = 0;
        first_cyc  = -1;
        finished   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (!finished && cyc < 300) begin
            set_ready(mode, cyc);
            if (restart && cyc == 2) begin
                start      = 1'b1;
                start_addr = 32'd0;
                num_words  = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                check("stall_valid_held", strm_if.out_valid, 1);
                check("stall_data_held", strm_if.out_data, prev_data);
                check("stall_last_held", strm_if.out_last, prev_last);
            end
            if (strm_if.out_valid && first_cyc < 0) begin
                first_cyc = cyc;
                check("first_valid_latency", cyc, 3);
            end
            if (done) begin
                check("beat_count", k, nw);
                check("done_timing", cyc, last_cyc + 1);
                check("done_err", err, 0);
                finished = 1'b1;
            end else begin
                check("busy", busy, 1);
                check("issue_credit", ((raddr - sa + 32'd1 - 32'(k)) <= B), 1);
                if (strm_if.out_valid && strm_if.out_ready) begin
                    idx = 4'(sa + 32'(k));
                    check("beat_data", strm_if.out_data, ram[idx]);
                    check("beat_last", strm_if.out_last, (k == int'(nw) - 1));
                    k++;
                    last_cyc = cyc;
                    if (abort_after != 0 && k == abort_after) begin
                        @(negedge clk);
                        start = 1'b0;
                        reset = 1'b1;
                        @(negedge clk);
                        check("abort_valid", strm_if.out_valid, 0);
                        check("abort_busy", busy, 0);
                        check("abort_done", done, 0);
                        reset = 1'b0;
                        for (int i = 0; i < 6; i++) begin
                            @(negedge clk);
                            check("abort_quiet", {31'd0, done || strm_if.out_valid}, 0);
                        end
                        return;
                    end
                end
            end
            prev_stall = strm_if.out_valid && !strm_if.out_ready;
            prev_data  = strm_if.out_data;
            prev_last  = strm_if.out_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!finished) begin
            check("timeout", 0, 1);
        end else begin
            check("after_done_clear", done, 0);
            check("after_busy_clear", busy, 0);
            check("after_no_extra_beat", strm_if.out_valid, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) ram[i] = W'(i + 16);
        reset              = 1'b1;
        start              = 1'b0;
        start_addr         = '0;
        num_words          = '0;
        strm_if.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_raddr", raddr, 0);
        check("reset_valid", strm_if.out_valid, 0);
        check("reset_last", strm_if.out_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        reset = 1'b0;

        run_cmd(32'd2, 32'd5, 0, 1'b0, 0);
        run_cmd(32'd2, 32'd5, 1, 1'b0, 0);
        run_cmd(32'd14, 32'd3, 0, 1'b0, 0);
        run_cmd(32'd5, 32'd0, 0, 1'b0, 0);
        run_cmd(32'd0, 32'd16, 2, 1'b0, 0);
        run_cmd(32'd0, 32'd10, 0, 1'b0, 3);
        run_cmd(32'd7, 32'd6, 0, 1'b0, 0);
        run_cmd(32'd1, 32'd8, 0, 1'b1, 0);
        run_cmd(32'd15, 32'd1, 1, 1'b0, 0);
        run_cmd(32'd0, 32'd17, 0, 1'b0, 0);
        run_cmd(32'd16, 32'd0, 0, 1'b0, 0);
        run_cmd(32'hFFFF_FFFF, 32'd2, 0, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < D; i++) ram[i] = W'($urandom);
            run_cmd(32'($urandom_range(0, 17)), 32'($urandom_range(0, 18)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
